kmeans_centroid_sorter: RTL and testbench

KMEANS_CENTROID_SORTER -- requirements
Module: kmeans_centroid_sorter

---
 rtl/kmeans_pkg.sv | 26 ++
 rtl/kmeans_cmp_swap.sv | 17 +
 rtl/kmeans_centroid_sorter.sv | 141 ++++++++++++++
 tb/tb_kmeans_centroid_sorter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: frame geometry, coordinate layout, controller states
// and the centroid ordering key.
package kmeans_pkg;

  localparam int unsigned CLUSTER_SIZE = 4;
  localparam int unsigned POINT_W      = 16;
  localparam int unsigned COORD_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StSort,
    StEmit
  } state_e;

  // Key is x then y, so a strict greater-than keeps equal words in arrival order.
  function automatic logic key_gt(input logic [POINT_W-1:0] a, input logic [POINT_W-1:0] b);
    logic [COORD_W-1:0] ax, ay, bx, by;
    ax = a[POINT_W-1 -: COORD_W];
    ay = a[COORD_W-1:0];
    bx = b[POINT_W-1 -: COORD_W];
    by = b[COORD_W-1:0];
    return (ax > bx) || ((ax == bx) && (ay > by));
  endfunction

endpackage

// File: rtl/kmeans_cmp_swap.sv
// Combinational compare-exchange of two centroid words; lo/hi are the ordered pair.
module kmeans_cmp_swap
  import kmeans_pkg::*;
(
  input  logic [POINT_W-1:0] a,
  input  logic [POINT_W-1:0] b,
  output logic [POINT_W-1:0] lo,
  output logic [POINT_W-1:0] hi
);

  logic swap;

  assign swap = key_gt(a, b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/kmeans_centroid_sorter.sv
// Collects a frame of centroid words, sorts it with a 4-phase odd-even transposition
// network and streams it out in ascending (x, y) order behind a valid/ready handshake.
module kmeans_centroid_sorter #(
  parameter int unsigned CLUSTER_SIZE = kmeans_pkg::CLUSTER_SIZE,
  parameter int unsigned POINT_W      = kmeans_pkg::POINT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [POINT_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POINT_W-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               frame_err,
  output logic               drop_err,
  output logic [7:0]         frame_cnt
);
  import kmeans_pkg::*;

  localparam int unsigned IDX_W = $clog2(CLUSTER_SIZE);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CLUSTER_SIZE - 1);

  state_e             state_q, state_d;
  logic [POINT_W-1:0] ent_q [CLUSTER_SIZE];
  logic [POINT_W-1:0] ent_d [CLUSTER_SIZE];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         step_q, step_d;
  logic               out_valid_d, out_last_d, busy_d, frame_err_d, drop_err_d;
  logic [POINT_W-1:0] out_data_d;
  logic [7:0]         frame_cnt_d;

  logic [POINT_W-1:0] s01_lo, s01_hi, s23_lo, s23_hi, s12_lo, s12_hi;

  kmeans_cmp_swap u_cs01 (.a(ent_q[0]), .b(ent_q[1]), .lo(s01_lo), .hi(s01_hi));
  kmeans_cmp_swap u_cs23 (.a(ent_q[2]), .b(ent_q[3]), .lo(s23_lo), .hi(s23_hi));
  kmeans_cmp_swap u_cs12 (.a(ent_q[1]), .b(ent_q[2]), .lo(s12_lo), .hi(s12_hi));

  always_comb begin
    state_d     = state_q;
    ent_d       = ent_q;
    idx_d       = idx_q;
    step_d      = step_q;
    frame_err_d = 1'b0;
    drop_err_d  = drop_err;
    frame_cnt_d = frame_cnt;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ent_d[0] = in_data;
          idx_d    = IDX_W'(1);
          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (in_valid) begin
          ent_d[idx_q] = in_data;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            step_d  = '0;
            state_d = StSort;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          for (int i = 0; i < CLUSTER_SIZE; i++) ent_d[i] = '0;
          idx_d       = '0;
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StSort: begin
        if (in_valid) drop_err_d = 1'b1;
        if (!step_q[0]) begin
          ent_d[0] = s01_lo;
          ent_d[1] = s01_hi;
          ent_d[2] = s23_lo;
          ent_d[3] = s23_hi;
        end else begin
          ent_d[1] = s12_lo;
          ent_d[2] = s12_hi;
        end
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          idx_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (in_valid) drop_err_d = 1'b1;
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d       = '0;
            frame_cnt_d = frame_cnt + 8'd1;
            state_d     = StIdle;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of what the next state will present.
    out_valid_d = (state_d == StEmit);
    out_data_d  = out_valid_d ? ent_d[idx_d] : '0;
    out_last_d  = out_valid_d && (idx_d == LastIdx);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      for (int i = 0; i < CLUSTER_SIZE; i++) ent_q[i] <= '0;
      idx_q     <= '0;
      step_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      drop_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      ent_q     <= ent_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      frame_err <= frame_err_d;
      drop_err  <= drop_err_d;
      frame_cnt <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_sorter.sv
// Directed bench for kmeans_centroid_sorter: sort order, latency, backpressure,
// short frames, dropped input, reset mid-frame and frame counter wrap.
module tb_kmeans_centroid_sorter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        frame_err;
  logic        drop_err;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kmeans_centroid_sorter #(
    .CLUSTER_SIZE(4),
    .POINT_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .frame_err(frame_err),
    .drop_err (drop_err),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 32) begin
      tick();
      n++;
    end
    chk(tag, {15'd0, out_valid}, 16'd1);
  endtask

  // Checks words first..3 with out_ready high, then that out_valid drops.
  task automatic check_words(input string tag, input int first,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    for (int i = first; i < 4; i++) begin
      chk($sformatf("%s_data%0d", tag, i), out_data, e[i]);
      chk($sformatf("%s_last%0d", tag, i), {15'd0, out_last}, (i == 3) ? 16'd1 : 16'd0);
      tick();
    end
    chk({tag, "_done_valid"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_done_data"}, out_data, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_data"}, out_data, 16'h0000);
    chk({tag, "_last"}, {15'd0, out_last}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_ferr"}, {15'd0, frame_err}, 16'd0);
    chk({tag, "_derr"}, {15'd0, drop_err}, 16'd0);
    chk({tag, "_cnt"}, {8'd0, frame_cnt}, 16'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Basic sort with latency check: first out_valid four edges after the 4th capture.
    send_frame(16'h3010, 16'h0520, 16'h3005, 16'h0101);
    chk("lat_busy", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lat_novalid%0d", i), {15'd0, out_valid}, 16'd0);
      chk($sformatf("lat_zero%0d", i), out_data, 16'h0000);
    end
    tick();
    chk("lat_valid", {15'd0, out_valid}, 16'd1);
    check_words("f1", 0, 16'h0101, 16'h0520, 16'h3005, 16'h3010);
    chk("f1_cnt", {8'd0, frame_cnt}, 16'd1);
    chk("f1_busy", {15'd0, busy}, 16'd0);

    // Duplicates all emitted.
    send_frame(16'h4444, 16'h4444, 16'h1000, 16'h4444);
    wait_valid("f2_wait");
    check_words("f2", 0, 16'h1000, 16'h4444, 16'h4444, 16'h4444);
    chk("f2_cnt", {8'd0, frame_cnt}, 16'd2);

    // Backpressure on word 1.
    send_frame(16'h3010, 16'h0520, 16'h3005, 16'h0101);
    wait_valid("bp_wait");
    chk("bp_w0", out_data, 16'h0101);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold%0d", i), out_data, 16'h0520);
      chk($sformatf("bp_last%0d", i), {15'd0, out_last}, 16'd0);
      chk($sformatf("bp_valid%0d", i), {15'd0, out_valid}, 16'd1);
      tick();
    end
    check_words("bp", 1, 16'h0101, 16'h0520, 16'h3005, 16'h3010);
    chk("bp_cnt", {8'd0, frame_cnt}, 16'd3);

    // Short frame: two words then a gap.
    in_valid = 1'b1;
    in_data  = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("short_busy_mid", {15'd0, busy}, 16'd1);
    tick();
    chk("short_ferr", {15'd0, frame_err}, 16'd1);
    chk("short_busy", {15'd0, busy}, 16'd0);
    chk("short_valid", {15'd0, out_valid}, 16'd0);
    tick();
    chk("short_ferr_pulse", {15'd0, frame_err}, 16'd0);
    chk("short_valid2", {15'd0, out_valid}, 16'd0);
    chk("short_cnt", {8'd0, frame_cnt}, 16'd3);

    // Input pulsed during EMIT is dropped and flagged.
    send_frame(16'h0202, 16'h0201, 16'h0102, 16'h0101);
    wait_valid("drop_wait");
    chk("drop_pre", {15'd0, drop_err}, 16'd0);
    chk("drop_w0", out_data, 16'h0101);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("drop_set", {15'd0, drop_err}, 16'd1);
    check_words("drop", 1, 16'h0101, 16'h0102, 16'h0201, 16'h0202);
    chk("drop_cnt", {8'd0, frame_cnt}, 16'd4);

    // New frame on the very first IDLE cycle after EMIT.
    send_frame(16'h0600, 16'h0500, 16'h0400, 16'h0300);
    wait_valid("b2b_wait");
    check_words("b2b", 0, 16'h0300, 16'h0400, 16'h0500, 16'h0600);
    chk("b2b_cnt", {8'd0, frame_cnt}, 16'd5);
    chk("drop_sticky", {15'd0, drop_err}, 16'd1);

    // Reset during SORT, then a clean frame.
    send_frame(16'h0900, 16'h0800, 16'h0700, 16'h0600);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_sort");
    tick();
    chk("rst_sort_idle_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_sort_idle_ferr", {15'd0, frame_err}, 16'd0);
    send_frame(16'h3010, 16'h0520, 16'h3005, 16'h0101);
    wait_valid("post_rst_wait");
    check_words("post_rst", 0, 16'h0101, 16'h0520, 16'h3005, 16'h3010);
    chk("post_rst_cnt", {8'd0, frame_cnt}, 16'd1);

    // Frame counter wrap: 255 more frames.
    for (int f = 0; f < 255; f++) begin
      send_frame(16'h0004, 16'h0003, 16'h0002, 16'h0001);
      wait_valid("wrap_wait");
      out_ready = 1'b1;
      repeat (4) tick();
      if (f == 253) chk("wrap_255", {8'd0, frame_cnt}, 16'd255);
    end
    chk("wrap_0", {8'd0, frame_cnt}, 16'd0);
    chk("wrap_idle", {15'd0, busy}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
